// File: rtl/keccak_pkg.sv
// Shared widths and FSM state encoding for the keccak feed controller.
package keccak_pkg;

  localparam int KECCAK_W   = 64;
  localparam int HASH_W     = 512;
  localparam int BYTE_NUM_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_RD   = 3'd2,
    ISSUE     = 3'd3,
    PAD       = 3'd4,
    WAIT_HASH = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/keccak_feed_ctrl.sv
// Pulls 64-bit message words from an external FIFO, feeds them to a keccak core
// with last-beat/byte-count tagging, appends a pad beat when needed, captures the digest.
module keccak_feed_ctrl
  import keccak_pkg::*;
#(
  parameter logic [31:0] MAX_LEN = 32'hFFFF_FFF8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           msg_len,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [KECCAK_W-1:0]   fifo_read_data,
  output logic [KECCAK_W-1:0]   keccak_input,
  output logic                  in_ready,
  output logic                  is_last,
  output logic [BYTE_NUM_W-1:0] byte_num,
  input  logic                  buffer_full,
  input  logic                  out_ready,
  input  logic [HASH_W-1:0]     keccak_out,
  output logic                  busy,
  output logic                  done,
  output logic [HASH_W-1:0]     hash_reg
);

  state_t                  state;
  logic [28:0]             words_left;
  logic [BYTE_NUM_W-1:0]   rem;
  logic [KECCAK_W-1:0]     data_q;
  logic [HASH_W-1:0]       hash_q;
  logic                    full_word;
  logic                    beat;

  assign full_word = (words_left != '0);

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    beat         = 1'b0;
    in_ready     = 1'b0;
    is_last      = 1'b0;
    byte_num     = '0;
    fifo_read_en = 1'b0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    if (state == FETCH) fifo_read_en = ~fifo_empty;
    if ((state == ISSUE || state == PAD) && !buffer_full) beat = 1'b1;
    if (beat) begin
      in_ready = 1'b1;
      if (state == PAD) begin
        is_last = 1'b1;
      end else if (!full_word) begin
        is_last  = 1'b1;
        byte_num = rem;
      end
    end
  end

  assign keccak_input = data_q;
  assign hash_reg     = hash_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      words_left <= '0;
      rem        <= '0;
      data_q     <= '0;
      hash_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (msg_len <= MAX_LEN)) begin
            words_left <= msg_len[31:3];
            rem        <= msg_len[2:0];
            if (msg_len != 32'd0) begin
              state <= FETCH;
            end else begin
              state  <= PAD;
              data_q <= '0;
            end
          end
        end
        FETCH: begin
          if (!fifo_empty) state <= WAIT_RD;
        end
        WAIT_RD: begin
          data_q <= fifo_read_data;
          state  <= ISSUE;
        end
        ISSUE: begin
          if (!buffer_full) begin
            if (full_word) begin
              words_left <= words_left - 29'd1;
              if ((words_left > 29'd1) || (rem != '0)) begin
                state <= FETCH;
              end else begin
                // The pad beat carries an all-zero word.
                state  <= PAD;
                data_q <= '0;
              end
            end else begin
              state <= WAIT_HASH;
            end
          end
        end
        PAD: begin
          if (!buffer_full) state <= WAIT_HASH;
        end
        WAIT_HASH: begin
          if (out_ready) begin
            hash_q <= keccak_out;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_feed_ctrl.sv
// Directed bench for keccak_feed_ctrl: FIFO model, beat scoreboard and digest checks.
module tb_keccak_feed_ctrl;

  typedef struct packed {
    logic        last;
    logic [2:0]  bn;
    logic [63:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   msg_len;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic [63:0]   fifo_read_data;
  logic [63:0]   keccak_input;
  logic          in_ready;
  logic          is_last;
  logic [2:0]    byte_num;
  logic          buffer_full;
  logic          out_ready;
  logic [511:0]  keccak_out;
  logic          busy;
  logic          done;
  logic [511:0]  hash_reg;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int pops_base, done_base, exp_pops;

  beat_t        exp_q[$];
  logic [63:0]  fq[$];
  logic [63:0]  pend_q[$];

  keccak_feed_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .keccak_input(keccak_input), .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
    .buffer_full(buffer_full), .out_ready(out_ready), .keccak_out(keccak_out),
    .busy(busy), .done(done), .hash_reg(hash_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word FIFO: pop on fifo_read_en, data valid the following cycle; a push shows up one edge later.
  always @(posedge clk) begin
    if (fifo_read_en && fq.size() != 0) fifo_read_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard: every beat is compared against the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      if (fifo_read_en) pop_cnt++;
      if (in_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_last", is_last, e.last);
          check("beat_bn", byte_num, e.bn);
          check("beat_data", keccak_input, e.data);
        end
      end else begin
        check("quiet_last", is_last, 0);
        check("quiet_bn", byte_num, 0);
      end
    end
  end

  function automatic logic [511:0] rand_hash();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, fifo_read_en, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_is_last"}, is_last, 0);
    check({tag, "_byte_num"}, byte_num, 0);
    check({tag, "_kin"}, keccak_input, 0);
    check({tag, "_hash"}, hash_reg, 0);
  endtask

  task automatic start_job(input logic [31:0] len, input int preload);
    int nfull = int'(len >> 3);
    int rem = int'(len & 32'd7);
    int nw = nfull + ((rem != 0) ? 1 : 0);
    beat_t b;
    pend_q.delete();
    for (int k = 0; k < nw; k++) begin
      b.data = {$urandom, $urandom};
      b.last = (k == nw - 1) && (rem != 0);
      b.bn   = b.last ? 3'(rem) : 3'd0;
      exp_q.push_back(b);
      if (k < preload) fq.push_back(b.data);
      else pend_q.push_back(b.data);
    end
    if (rem == 0) begin
      b.last = 1'b1; b.bn = 3'd0; b.data = '0;
      exp_q.push_back(b);
    end
    exp_pops  = nw;
    pops_base = pop_cnt;
    done_base = done_cnt;
    @(posedge clk) #1 start = 1'b1; msg_len = len;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic feed_rest();
    while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_beats_drained"}, exp_q.size() == 0, 1);
  endtask

  task automatic finish_job(input string tag);
    logic [511:0] h;
    h = rand_hash();
    wait_drained(tag);
    repeat (2) @(negedge clk);
    check({tag, "_no_early_done"}, done, 0);
    check({tag, "_busy_wait_hash"}, busy, 1);
    @(posedge clk) #1 out_ready = 1'b1; keccak_out = h;
    @(posedge clk) #1 out_ready = 1'b0; keccak_out = ~h;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_hash_capture"}, hash_reg, h);
    @(negedge clk);
    check({tag, "_done_clear"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hash_hold"}, hash_reg, h);
    check({tag, "_pops"}, pop_cnt - pops_base, exp_pops);
    check({tag, "_done_count"}, done_cnt - done_base, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] held;
    int dc;
    reset = 1'b1; start = 1'b0; msg_len = '0; buffer_full = 1'b0;
    out_ready = 1'b0; keccak_out = '0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Oversized length is ignored.
    @(posedge clk) #1 start = 1'b1; msg_len = 32'hFFFF_FFFF;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk);
    check("oversize_busy", busy, 0);
    check("oversize_rd_en", fifo_read_en, 0);

    // Two full words then the pad beat.
    start_job(32'd16, 2);
    finish_job("len16");

    // Full word then a 3-byte tail word, no pad beat.
    start_job(32'd11, 2);
    finish_job("len11");

    // Empty message: only the pad beat.
    start_job(32'd0, 0);
    finish_job("len0");

    // Back-pressure while a word waits in ISSUE.
    buffer_full = 1'b1;
    start_job(32'd8, 1);
    held = exp_q[0].data;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bf_in_ready_low", in_ready, 0);
      check("bf_kin_stable", keccak_input, held);
    end
    @(posedge clk) #1 buffer_full = 1'b0;
    @(negedge clk);
    check("bf_issue", in_ready, 1);
    finish_job("bf");

    // FIFO runs dry mid-job; a start pulse while busy must be ignored.
    start_job(32'd24, 1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; msg_len = 32'd8;
    @(negedge clk);
    check("dry_rd_en_0", fifo_read_en, 0);
    @(posedge clk) #1 start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("dry_rd_en", fifo_read_en, 0);
    end
    feed_rest();
    finish_job("dry");
    repeat (3) @(negedge clk);
    check("dry_no_restart", busy, 0);

    // Reset while waiting for the hash.
    start_job(32'd8, 1);
    wait_drained("rst");
    repeat (2) @(negedge clk);
    dc = done_cnt;
    reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    check("midrst_idle", busy, 0);
    start_job(32'd13, 2);
    finish_job("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
